doorlock_pw_ctrl: RTL

Password controller directly downstream of the star-key confirm stage and the numeric keypad stage. Collects digit pulses into an entry buffer, checks the buffer against the stored password on a short confirm, and drives the unlock output. Long confirm while open enters password-change mode. Consecutive failures are counted and lead to a timed lockout.

---
 rtl/doorlock_pw_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/doorlock_pw_ctrl.sv
// ---------------------------------------------------------------------------
// doorlock_pw_ctrl
//   Password controller for a keypad door lock. Digit pulses are shifted into
//   an entry buffer. A short confirm compares the buffer against the stored
//   password and opens the door for a timed window. A long confirm while the
//   door is open enters password-change mode. Consecutive wrong entries are
//   counted, and reaching MAX_FAIL starts a timed lockout.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   num_valid    in   one-cycle pulse, num_digit is valid
//   num_digit    in   [3:0] BCD digit 0..9 (larger codes are dropped)
//   confirm      in   one-cycle short-press pulse
//   long_confirm in   one-cycle long-press pulse
//   unlock       out  door open level
//   error        out  one-cycle pulse: wrong password / new password too short
//   pw_changed   out  one-cycle pulse: a new password has been stored
//   locked_out   out  high for the duration of a lockout
//   digit_count  out  [3:0] digits currently held in the entry buffer
//   state        out  [2:0] FSM state (IDLE=0 CHECK=1 OPEN=2 NEW_PW=3 LOCKOUT=4)
// ---------------------------------------------------------------------------
module doorlock_pw_ctrl #(
   parameter int                      MAX_DIGITS     = 8,
   parameter int                      MIN_DIGITS     = 4,
   parameter logic [4*MAX_DIGITS-1:0] DEFAULT_PW     = (4*MAX_DIGITS)'(32'h0000_1234),
   parameter int                      DEFAULT_LEN    = 4,
   parameter int                      MAX_FAIL       = 3,
   parameter logic [23:0]             UNLOCK_CYCLES  = 24'd5000000,
   parameter logic [23:0]             LOCKOUT_CYCLES = 24'd15000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       num_valid,
   input  logic [3:0] num_digit,
   input  logic       confirm,
   input  logic       long_confirm,
   output logic       unlock,
   output logic       error,
   output logic       pw_changed,
   output logic       locked_out,
   output logic [3:0] digit_count,
   output logic [2:0] state
);

   localparam int BW = 4 * MAX_DIGITS;
   localparam int FW = (MAX_FAIL < 2) ? 1 : $clog2(MAX_FAIL + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CHECK   = 3'd1,
      S_OPEN    = 3'd2,
      S_NEW_PW  = 3'd3,
      S_LOCKOUT = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   buf_q, buf_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [BW-1:0]   pw_q, pw_d;
   logic [3:0]      pw_len_q, pw_len_d;
   logic [FW-1:0]   fail_q, fail_d;
   logic [23:0]     timer_q, timer_d;
   logic            error_q, error_d;
   logic            pwc_q, pwc_d;

   logic            digit_ok;
   logic [BW-1:0]   buf_shift;

   // A digit is only accepted if it is real BCD and there is room for it.
   assign digit_ok  = num_valid && (num_digit <= 4'd9) && (cnt_q < 4'(MAX_DIGITS));
   assign buf_shift = {buf_q[BW-5:0], num_digit};

   // ------------------------------------------------------------------------
   // State and data registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         buf_q    <= '0;
         cnt_q    <= '0;
         pw_q     <= DEFAULT_PW;
         pw_len_q <= 4'(DEFAULT_LEN);
         fail_q   <= '0;
         timer_q  <= '0;
         error_q  <= 1'b0;
         pwc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         buf_q    <= buf_d;
         cnt_q    <= cnt_d;
         pw_q     <= pw_d;
         pw_len_q <= pw_len_d;
         fail_q   <= fail_d;
         timer_q  <= timer_d;
         error_q  <= error_d;
         pwc_q    <= pwc_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      buf_d    = buf_q;
      cnt_d    = cnt_q;
      pw_d     = pw_q;
      pw_len_d = pw_len_q;
      fail_d   = fail_q;
      error_d  = 1'b0;
      pwc_d    = 1'b0;
      timer_d  = timer_q;

      // The timer only runs in the timed states and holds at all-ones so it
      // can never wrap back into a terminal-count match.
      if ((state_q == S_OPEN || state_q == S_LOCKOUT) && (timer_q != 24'hFF_FFFF))
         timer_d = timer_q + 24'd1;

      unique case (state_q)
         S_IDLE: begin
            // confirm wins over a digit arriving in the same cycle;
            // long_confirm has no meaning here.
            if (confirm) begin
               state_d = S_CHECK;
            end else if (digit_ok) begin
               buf_d = buf_shift;
               cnt_d = cnt_q + 4'd1;
            end
         end

         S_CHECK: begin
            buf_d = '0;
            cnt_d = '0;
            if ((cnt_q == pw_len_q) && (buf_q == pw_q)) begin
               fail_d  = '0;
               state_d = S_OPEN;
            end else begin
               error_d = 1'b1;
               fail_d  = fail_q + 1'b1;
               if (fail_q == FW'(MAX_FAIL - 1))
                  state_d = S_LOCKOUT;
               else
                  state_d = S_IDLE;
            end
         end

         S_OPEN: begin
            if (confirm) begin
               state_d = S_IDLE;
            end else if (long_confirm) begin
               buf_d   = '0;
               cnt_d   = '0;
               state_d = S_NEW_PW;
            end else if (timer_q == UNLOCK_CYCLES - 24'd1) begin
               state_d = S_IDLE;
            end
         end

         S_NEW_PW: begin
            if (confirm) begin
               // Either way the entry is consumed; a short entry must be
               // retyped from scratch.
               buf_d = '0;
               cnt_d = '0;
               if (cnt_q >= 4'(MIN_DIGITS)) begin
                  pw_d     = buf_q;
                  pw_len_d = cnt_q;
                  pwc_d    = 1'b1;
                  state_d  = S_IDLE;
               end else begin
                  error_d = 1'b1;
               end
            end else if (long_confirm) begin
               buf_d   = '0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else if (digit_ok) begin
               buf_d = buf_shift;
               cnt_d = cnt_q + 4'd1;
            end
         end

         S_LOCKOUT: begin
            if (timer_q == LOCKOUT_CYCLES - 24'd1) begin
               fail_d  = '0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Every state entry starts the timer from zero.
      if (state_d != state_q)
         timer_d = '0;
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign unlock      = (state_q == S_OPEN);
   assign locked_out  = (state_q == S_LOCKOUT);
   assign error       = error_q;
   assign pw_changed  = pwc_q;
   assign digit_count = cnt_q;
   assign state       = state_q;

endmodule
